// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register and its serializer controller.
//   USR_HOLD/USR_SHR/USR_SHL/USR_LOAD : 2-bit shift register mode encodings
//   usr_ser_state_t                   : serializer controller FSM states
package usr_pkg;

  localparam logic [1:0] USR_HOLD = 2'b00;
  localparam logic [1:0] USR_SHR  = 2'b01;  // {data_in[0], q[W-1:1]}
  localparam logic [1:0] USR_SHL  = 2'b10;  // {q[W-2:0], data_in[0]}
  localparam logic [1:0] USR_LOAD = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT
  } usr_ser_state_t;

endpackage

// File: rtl/universal_shift_register.sv
// Universal shift register: hold, shift right, shift left or parallel load.
//   clk      : clock, rising edge
//   reset    : synchronous active-high reset, clears the register
//   mode     : operation select (usr_pkg mode encodings)
//   data_in  : parallel load value; bit 0 is the serial fill bit for shifts
//   data_out : register contents
module UniversalShiftRegister
  import usr_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    unique case (mode)
      USR_HOLD: q_d = q_q;
      USR_SHR:  q_d = {data_in[0], q_q[WIDTH-1:1]};
      USR_SHL:  q_d = {q_q[WIDTH-2:0], data_in[0]};
      USR_LOAD: q_d = data_in;
      default:  q_d = q_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign data_out = q_q;

endmodule

// File: rtl/usr_serializer_ctrl.sv
// Parallel-to-serial sequencer driving a universal shift register.
// Accepts a word on a valid/ready handshake, loads it into the shift register, then
// shifts it out WIDTH times in the requested direction, reporting each departing bit.
//   clk, reset              : clock and synchronous active-high reset
//   in_valid/in_ready       : word handshake
//   in_data, in_msb_first   : word and bit order (1 = MSB first, left shift)
//   pause                   : stalls shifting while high (ignored in the load cycle)
//   sr_mode, sr_data_in     : drive the shift register mode / data_in
//   sr_q                    : shift register data_out feedback
//   ser_out/valid/last      : serial bit, its qualifier and end-of-word flag
//   busy                    : a word is being loaded or shifted
module usr_serializer_ctrl
  import usr_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_msb_first,
  input  logic             pause,
  output logic [1:0]       sr_mode,
  output logic [WIDTH-1:0] sr_data_in,
  input  logic [WIDTH-1:0] sr_q,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last,
  output logic             busy
);

  localparam int unsigned     CntW    = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  usr_ser_state_t   state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             dir_q, dir_d;

  logic last_bit;
  logic accept;

  // Only the departing end of the register is observed.
  logic unused_sr_q;
  assign unused_sr_q = ^sr_q;

  assign last_bit = (state_q == SHIFT) && !pause && (cnt_q == CntLast);
  assign accept   = in_valid && in_ready;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      dir_q   <= dir_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    dir_d   = dir_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = LOAD;
          word_d  = in_data;
          dir_d   = in_msb_first;
        end
      end
      LOAD: begin
        cnt_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        if (!pause) begin
          if (last_bit) begin
            // Back-to-back: a word offered on the last bit skips IDLE.
            if (accept) begin
              state_d = LOAD;
              word_d  = in_data;
              dir_d   = in_msb_first;
            end else begin
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode; everything is forced low while reset is held.
  always_comb begin
    in_ready   = 1'b0;
    busy       = 1'b0;
    sr_mode    = USR_HOLD;
    sr_data_in = '0;
    ser_out    = 1'b0;
    ser_valid  = 1'b0;
    ser_last   = 1'b0;
    if (!reset) begin
      busy = (state_q != IDLE);
      unique case (state_q)
        IDLE: in_ready = 1'b1;
        LOAD: begin
          sr_mode    = USR_LOAD;
          sr_data_in = word_q;
        end
        SHIFT: begin
          if (!pause) begin
            sr_mode   = dir_q ? USR_SHL : USR_SHR;
            ser_valid = 1'b1;
            ser_out   = dir_q ? sr_q[WIDTH-1] : sr_q[0];
            ser_last  = last_bit;
            in_ready  = last_bit;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/usr_serializer_ctrl.md
# usr_serializer_ctrl

Sequencer that sits directly upstream of the 4-bit universal shift register and drives its `mode` and `data_in` inputs. It turns that register into a parallel-to-serial transmitter. It accepts a parallel word on a valid/ready handshake, issues one parallel load, then issues WIDTH shift commands in the requested direction. It emits the bit leaving the register each shift cycle, with valid and last-bit flags.

## Interface
- `WIDTH`, default 4: word width; must match the shift register; WIDTH ≥ 2.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `in_valid` input 1: upstream word available.
- `in_ready` output 1: block accepts a word this cycle.
- `in_data` input WIDTH: word to serialize.
- `in_msb_first` input 1: 1 = MSB first (left shift); 0 = LSB first (right shift); sampled with the word.
- `pause` input 1: stalls shifting while high.
- `sr_mode` output 2: to the shift register `mode`.
- `sr_data_in` output WIDTH: to the shift register `data_in`.
- `sr_q` input WIDTH: feedback from the shift register `data_out`.
- `ser_out` output 1: serial bit, valid when `ser_valid` is high; 0 otherwise.
- `ser_valid` output 1: `ser_out` is a transmitted bit this cycle.
- `ser_last` output 1: final bit of the current word.
- `busy` output 1: state is not IDLE.

## Operation
- Mode encoding: HOLD=00, SHR=01 (`{data_in[0], q[W-1:1]}`), SHL=10 (`{q[W-2:0], data_in[0]}`), LOAD=11.
- FSM states:
  - **IDLE**: `in_ready`=1, `sr_mode`=HOLD. On `in_valid & in_ready`, capture `in_data` into `word_r` and `in_msb_first` into `dir_r`, then go to LOAD.
  - **LOAD**: `sr_mode`=LOAD, `sr_data_in`=`word_r`; lasts exactly one cycle and is unaffected by `pause`. Clears `cnt`, then goes to SHIFT.
  - **SHIFT**, `pause`=0:
    - `sr_mode` = SHL if `dir_r`, else SHR; `sr_data_in` = 0 (shift-in fill is 0).
    - `ser_valid`=1; `ser_out` = `sr_q[WIDTH-1]` if `dir_r`, else `sr_q[0]`.
    - `cnt` increments.
  - **SHIFT**, `pause`=1: `sr_mode`=HOLD, `ser_valid`=0, `ser_last`=0, `cnt` holds.
  - Last bit: when `cnt`==WIDTH-1 and `pause`=0, `ser_last`=1 and `in_ready`=1. A handshake in that cycle goes straight to LOAD (back-to-back); otherwise go to IDLE.
- `sr_mode`, `sr_data_in`, `ser_*` and `in_ready` are combinational decodes of registered state plus `pause`/`sr_q`. There is no combinational path from `in_valid` to any output.
- `cnt` is `$clog2(WIDTH)` bits wide and never exceeds WIDTH-1. It does not wrap: the FSM leaves SHIFT at WIDTH-1.
- `in_valid` outside IDLE or the last-bit cycle is ignored; upstream must hold the word until `in_ready`.

## Timing
- Reset: state=IDLE, `cnt`=0, `word_r`=0, `dir_r`=0. While `reset` is high, outputs are forced as follows:
  - `in_ready`=0, `busy`=0;
  - `sr_mode`=00, `sr_data_in`=0;
  - `ser_out`=0, `ser_valid`=0, `ser_last`=0.
- Reset mid-word: the FSM is in IDLE after the next edge and the word is discarded. The shift register shares `reset`, so it clears in the same cycle.
- Latency: with the handshake at cycle T, LOAD is at T+1 and the first `ser_valid` is at T+2. Without pauses, `ser_last` is at T+1+WIDTH.
- Throughput: one word per WIDTH+1 cycles back-to-back; WIDTH+2 cycles with an IDLE gap.
- A pause in the LOAD cycle is ignored. A pause in the last-bit cycle defers `ser_last` and `in_ready` until `pause` falls.

## Structure
- Shared package `usr_pkg`:
  - mode constants `USR_HOLD`, `USR_SHR`, `USR_SHL`, `USR_LOAD`, also used by the shift register;
  - FSM state enum `usr_ser_state_t` {IDLE, LOAD, SHIFT}.
- No sub-module. The parent (or bench) instantiates this block and UniversalShiftRegister side by side, with `sr_mode`/`sr_data_in`/`sr_q` wired to its `mode`/`data_in`/`data_out`.

## Test plan
All scenarios use the controller and shift register connected together, WIDTH=4.
- Reset, then handshake 1011 with LSB first at cycle T:
  - LOAD at T+1;
  - `ser_out` = 1,1,0,1 at T+2..T+5;
  - `ser_last` only at T+5, IDLE at T+6;
  - `sr_q` at T+6 = 0000.
- 1011 with MSB first → `ser_out` = 1,0,1,1; `sr_mode` = 10 on each shift cycle.
- 0101 LSB first with `pause` high for 2 cycles after the first bit:
  - `sr_mode`=00 and `ser_valid`=0 during the pause;
  - bits remain 1,0,1,0;
  - `ser_last` is delayed 2 cycles.
- Back-to-back: 1011 then 0101, with `in_valid` held → second word accepted on the `ser_last` cycle. Stream is 1,1,0,1,(LOAD gap),1,0,1,0, and `busy` stays high throughout.
- `reset` asserted after 2 bits → next cycle: IDLE, `ser_valid`=0, `sr_q`=0000. A new word 0110 then serializes as 0,1,1,0.
- `in_valid` pulsed during SHIFT (not the last bit) → ignored; no extra LOAD and the stream is unchanged.
